// File: rtl/wait_state_memory.sv
// Word-addressed memory slave with programmable read/write wait states, a
// read-only instruction region, error reporting and a saturating write counter.
module wait_state_memory #(
  parameter int unsigned      WIDTH       = 32,
  parameter int unsigned      DEPTH       = 256,
  parameter int unsigned      DATA_BASE   = 20,
  parameter bit               ROM_PROTECT = 1'b1,
  parameter int unsigned      RD_LAT      = 2,
  parameter int unsigned      WR_LAT      = 1,
  // Stands in for the Processor NOP encoding; override to match the ISA in use.
  parameter logic [WIDTH-1:0] IDLE_WORD   = WIDTH'(32'h0000_0013),
  parameter string            INIT_FILE   = ""
) (
  input  logic             iClk,
  input  logic             iRst,
  input  logic             iMemRead,
  input  logic             iMemWrite,
  input  logic [31:0]      iMemAddr,
  input  logic [WIDTH-1:0] iMemData,
  output logic [WIDTH-1:0] oMemData,
  output logic             oMemRdy,
  output logic             oErr,
  output logic [15:0]      oWrCount
);

  localparam int unsigned AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [3:0]  RdLat = 4'(RD_LAT);
  localparam logic [3:0]  WrLat = 4'(WR_LAT);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e           state_q, state_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [31:0]      addr_q, addr_d;
  logic [WIDTH-1:0] wdata_q, wdata_d;
  logic             wr_q, wr_d;
  logic             both_q, both_d;
  logic [WIDTH-1:0] rdata_q, rdata_d;
  logic             err_q, err_d;
  logic [15:0]      wr_count_q, wr_count_d;

  logic             enter_done;
  logic             acc_err;
  logic             mem_we;
  logic [AW-1:0]    idx;

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    wr_d    = wr_q;
    both_d  = both_q;
    unique case (state_q)
      StIdle: begin
        if (iMemRead || iMemWrite) begin
          addr_d  = iMemAddr;
          wdata_d = iMemData;
          wr_d    = iMemWrite;
          both_d  = iMemRead && iMemWrite;
          // A simultaneous read+write takes the write latency.
          cnt_d   = iMemWrite ? WrLat : RdLat;
          state_d = (cnt_d != 4'd0) ? StWait : StDone;
        end
      end
      StWait: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // addr_d/wr_d/both_d always hold the access in flight, whether it was
  // accepted this edge or earlier, so commit can use them uniformly.
  always_comb begin
    enter_done = (state_d == StDone) && (state_q != StDone);
    acc_err    = (addr_d >= 32'(DEPTH)) ||
                 (wr_d && ROM_PROTECT && (addr_d < 32'(DATA_BASE))) ||
                 both_d;
    idx        = addr_d[AW-1:0];
    mem_we     = enter_done && wr_d && !acc_err && !iRst;
    rdata_d    = rdata_q;
    err_d      = err_q;
    wr_count_d = wr_count_q;
    if (enter_done) begin
      err_d   = acc_err;
      rdata_d = (acc_err || wr_d) ? '0 : mem_q[idx];
      if (wr_d && !acc_err && (wr_count_q != 16'hFFFF)) wr_count_d = wr_count_q + 16'd1;
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_q       <= 1'b0;
      both_q     <= 1'b0;
      rdata_q    <= '0;
      err_q      <= 1'b0;
      wr_count_q <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_q       <= wr_d;
      both_q     <= both_d;
      rdata_q    <= rdata_d;
      err_q      <= err_d;
      wr_count_q <= wr_count_d;
    end
  end

  // Array is deliberately left out of reset.
  always_ff @(posedge iClk) begin
    if (mem_we) mem_q[idx] <= wdata_d;
  end

  always_comb begin
    oMemRdy  = (state_q == StDone);
    oErr     = oMemRdy && err_q;
    oMemData = oMemRdy ? rdata_q : IDLE_WORD;
    oWrCount = wr_count_q;
  end

endmodule

// File: tb/tb_wait_state_memory.sv
// Randomised self-checking bench for wait_state_memory: one instance with
// RD_LAT=2/WR_LAT=1 and one with zero wait states, against an array model.
module tb_wait_state_memory;

  localparam logic [31:0] Nop      = 32'h0000_0013;
  localparam int          Depth    = 256;
  localparam int          DataBase = 20;
  localparam int          RdLatTb [2] = '{2, 0};
  localparam int          WrLatTb [2] = '{1, 0};

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rd    [2];
  logic        wr    [2];
  logic [31:0] addr  [2];
  logic [31:0] wdata [2];
  logic [31:0] q     [2];
  logic        rdy   [2];
  logic        err   [2];
  logic [15:0] wcnt  [2];

  logic [31:0] mem_m   [2][Depth];
  bit          known_m [2][Depth];
  int          cnt_m   [2];

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  wait_state_memory #(
    .WIDTH(32), .DEPTH(Depth), .DATA_BASE(DataBase), .ROM_PROTECT(1'b1),
    .RD_LAT(2), .WR_LAT(1), .IDLE_WORD(Nop), .INIT_FILE("")
  ) dut (
    .iClk(clk), .iRst(rst), .iMemRead(rd[0]), .iMemWrite(wr[0]), .iMemAddr(addr[0]),
    .iMemData(wdata[0]), .oMemData(q[0]), .oMemRdy(rdy[0]), .oErr(err[0]),
    .oWrCount(wcnt[0])
  );

  wait_state_memory #(
    .WIDTH(32), .DEPTH(Depth), .DATA_BASE(DataBase), .ROM_PROTECT(1'b1),
    .RD_LAT(0), .WR_LAT(0), .IDLE_WORD(Nop), .INIT_FILE("")
  ) dut0 (
    .iClk(clk), .iRst(rst), .iMemRead(rd[1]), .iMemWrite(wr[1]), .iMemAddr(addr[1]),
    .iMemData(wdata[1]), .oMemData(q[1]), .oMemRdy(rdy[1]), .oErr(err[1]),
    .oWrCount(wcnt[1])
  );

  // Raises the request at a falling edge, scrambles addr/data after accept,
  // and returns the number of falling edges until Rdy (-1 on timeout).
  task automatic access(input int sel, input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d, output int cyc, output logic [31:0] rq,
                        output logic re);
    @(negedge clk);
    rd[sel] = r; wr[sel] = w; addr[sel] = a; wdata[sel] = d;
    cyc = -1; rq = 'x; re = 1'bx;
    for (int i = 1; i <= 40; i++) begin
      @(negedge clk);
      if (rdy[sel] === 1'b1) begin
        cyc = i; rq = q[sel]; re = err[sel];
        break;
      end
      addr[sel] = $urandom; wdata[sel] = $urandom;
    end
    rd[sel] = 1'b0; wr[sel] = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        total++;
        if (rdy[s] !== 1'b0 || err[s] !== 1'b0 || q[s] !== Nop || wcnt[s] !== 16'd0)
          $display("FAIL reset_idle[%0d]: rdy=%b err=%b data=%h cnt=%0d want 0 0 %h 0",
                   s, rdy[s], err[s], q[s], wcnt[s], Nop);
        else passed++;
      end
    end
  endtask

  task automatic test_read_latency();
    int c; logic [31:0] v; logic e;
    access(0, 1'b0, 1'b1, 32'd20, 32'h22, c, v, e);
    mem_m[0][20] = 32'h22; known_m[0][20] = 1'b1; cnt_m[0]++;
    total++;
    if (c !== 2 || e !== 1'b0) $display("FAIL preload_wr: cyc=%0d err=%b want 2 0", c, e);
    else passed++;
    access(0, 1'b1, 1'b0, 32'd20, 32'h0, c, v, e);
    total++;
    if (c !== 3) $display("FAIL read_lat: cyc=%0d want 3", c); else passed++;
    total++;
    if (v !== 32'h22 || e !== 1'b0) $display("FAIL read_data: %h err=%b want 22 0", v, e);
    else passed++;
    @(negedge clk);
    total++;
    if (q[0] !== Nop || rdy[0] !== 1'b0)
      $display("FAIL read_after_nop: data=%h rdy=%b want %h 0", q[0], rdy[0], Nop);
    else passed++;
  endtask

  task automatic test_write_read();
    int c; logic [31:0] v; logic e;
    access(0, 1'b0, 1'b1, 32'd23, 32'h20, c, v, e);
    mem_m[0][23] = 32'h20; known_m[0][23] = 1'b1; cnt_m[0]++;
    total++;
    if (c !== 2 || e !== 1'b0 || v !== 32'h0)
      $display("FAIL wr23: cyc=%0d err=%b data=%h want 2 0 0", c, e, v);
    else passed++;
    total++;
    if (wcnt[0] !== 16'(cnt_m[0])) $display("FAIL wr23_cnt: %0d want %0d", wcnt[0], cnt_m[0]);
    else passed++;
    access(0, 1'b1, 1'b0, 32'd23, 32'h0, c, v, e);
    total++;
    if (c !== 3 || v !== 32'h20 || e !== 1'b0)
      $display("FAIL rd23: cyc=%0d data=%h err=%b want 3 20 0", c, v, e);
    else passed++;
  endtask

  task automatic test_errors();
    int c; logic [31:0] v; logic e;
    access(0, 1'b0, 1'b1, 32'd5, 32'hBAD0_0005, c, v, e);
    total++;
    if (c !== 2 || e !== 1'b1 || v !== 32'h0)
      $display("FAIL rom_wr: cyc=%0d err=%b data=%h want 2 1 0", c, e, v);
    else passed++;
    access(0, 1'b1, 1'b0, 32'd300, 32'h0, c, v, e);
    total++;
    if (c !== 3 || e !== 1'b1 || v !== 32'h0)
      $display("FAIL oob_rd: cyc=%0d err=%b data=%h want 3 1 0", c, e, v);
    else passed++;
    access(0, 1'b0, 1'b1, 32'd25, 32'hA5A5_0025, c, v, e);
    mem_m[0][25] = 32'hA5A5_0025; known_m[0][25] = 1'b1; cnt_m[0]++;
    // Read+write together: error, write latency, array untouched.
    access(0, 1'b1, 1'b1, 32'd25, 32'h5A5A_FFFF, c, v, e);
    total++;
    if (c !== 2 || e !== 1'b1 || v !== 32'h0)
      $display("FAIL both_hi: cyc=%0d err=%b data=%h want 2 1 0", c, e, v);
    else passed++;
    access(0, 1'b1, 1'b0, 32'd25, 32'h0, c, v, e);
    total++;
    if (v !== 32'hA5A5_0025 || e !== 1'b0)
      $display("FAIL keep25: data=%h err=%b want a5a50025 0", v, e);
    else passed++;
    total++;
    if (wcnt[0] !== 16'(cnt_m[0])) $display("FAIL err_cnt: %0d want %0d", wcnt[0], cnt_m[0]);
    else passed++;
  endtask

  task automatic test_zero_latency();
    int c; logic [31:0] a, b, v; logic e;
    access(1, 1'b0, 1'b1, 32'd20, 32'h22, c, v, e);
    access(1, 1'b0, 1'b1, 32'd21, 32'h24, c, v, e);
    cnt_m[1] += 2;
    access(1, 1'b1, 1'b0, 32'd20, 32'h0, c, a, e);
    total++;
    if (c !== 1 || a !== 32'h22 || e !== 1'b0)
      $display("FAIL z_ld20: cyc=%0d data=%h err=%b want 1 22 0", c, a, e);
    else passed++;
    access(1, 1'b1, 1'b0, 32'd21, 32'h0, c, b, e);
    access(1, 1'b0, 1'b1, 32'd23, a & b, c, v, e);
    cnt_m[1]++;
    total++;
    if (c !== 1 || e !== 1'b0) $display("FAIL z_st23: cyc=%0d err=%b want 1 0", c, e);
    else passed++;
    access(1, 1'b1, 1'b0, 32'd23, 32'h0, c, v, e);
    total++;
    if (v !== 32'h20 || e !== 1'b0) $display("FAIL z_ld23: data=%h err=%b want 20 0", v, e);
    else passed++;
    mem_m[1][20] = 32'h22; mem_m[1][21] = 32'h24; mem_m[1][23] = 32'h20;
    known_m[1][20] = 1'b1; known_m[1][21] = 1'b1; known_m[1][23] = 1'b1;
  endtask

  task automatic test_random();
    int c, lat, ai, kind; logic r, w, e, ee; logic [31:0] a, d, v, ed; logic [1:0] rw;
    for (int n = 0; n < 60; n++) begin
      int s = n % 2;
      kind = $urandom_range(0, 3);
      d = $urandom;
      unique case (kind)
        0: begin r = 1'b0; w = 1'b1; ai = $urandom_range(20, 63); end
        1: begin r = 1'b1; w = 1'b0; ai = $urandom_range(20, 63); end
        2: begin rw = 2'($urandom_range(1, 3)); r = rw[0]; w = rw[1]; ai = $urandom_range(0, 319); end
        default: begin r = 1'b1; w = 1'b1; ai = $urandom_range(0, 63); end
      endcase
      a = 32'(ai);
      ee  = (ai >= Depth) || (w && ai < DataBase) || (r && w);
      lat = w ? WrLatTb[s] : RdLatTb[s];
      ed  = (ee || w) ? 32'h0 : mem_m[s][ai];
      access(s, r, w, a, d, c, v, e);
      total++;
      if (c !== lat + 1 || e !== ee)
        $display("FAIL rnd%0d[%0d] a=%0d r=%b w=%b: cyc=%0d err=%b want %0d %b",
                 n, s, ai, r, w, c, e, lat + 1, ee);
      else passed++;
      if (ee || w || known_m[s][ai]) begin
        total++;
        if (v !== ed) $display("FAIL rnd%0d_data[%0d] a=%0d: %h want %h", n, s, ai, v, ed);
        else passed++;
      end
      if (w && !ee) begin
        mem_m[s][ai] = d; known_m[s][ai] = 1'b1; cnt_m[s]++;
      end
    end
    for (int s = 0; s < 2; s++) begin
      total++;
      if (wcnt[s] !== 16'(cnt_m[s])) $display("FAIL rnd_cnt[%0d]: %0d want %0d", s, wcnt[s], cnt_m[s]);
      else passed++;
    end
  endtask

  task automatic test_reset_abort();
    int c; logic [31:0] v; logic e; bit seen;
    access(0, 1'b0, 1'b1, 32'd30, 32'h1111_0030, c, v, e);
    mem_m[0][30] = 32'h1111_0030; cnt_m[0]++;
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 32'd30; wdata[0] = 32'h2222_0030;
    @(negedge clk);
    // Accept edge has passed; reset now lands on the would-be DONE edge.
    rst = 1'b1; wr[0] = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (rdy[0] !== 1'b0) seen = 1'b1;
      @(negedge clk);
    end
    total++;
    if (seen) $display("FAIL abort_rdy: rdy seen=1 want 0"); else passed++;
    // Reset returns the counter to zero; the aborted write must not add to it.
    cnt_m[0] = 0; cnt_m[1] = 0;
    total++;
    if (wcnt[0] !== 16'd0) $display("FAIL abort_cnt: %0d want 0", wcnt[0]); else passed++;
    access(0, 1'b1, 1'b0, 32'd30, 32'h0, c, v, e);
    total++;
    if (c !== 3 || v !== 32'h1111_0030 || e !== 1'b0)
      $display("FAIL abort_rd30: cyc=%0d data=%h err=%b want 3 11110030 0", c, v, e);
    else passed++;
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      rd[s] = 1'b0; wr[s] = 1'b0; addr[s] = '0; wdata[s] = '0; cnt_m[s] = 0;
      for (int i = 0; i < Depth; i++) begin
        mem_m[s][i] = '0; known_m[s][i] = 1'b0;
      end
    end
    test_reset();
    test_read_latency();
    test_write_read();
    test_errors();
    test_zero_latency();
    test_random();
    test_reset_abort();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
